lsu_mem_if: RTL

LSU_MEM_IF -- requirements
Module: lsu_mem_if

---
 rtl/lsu_mem_if.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/lsu_mem_if.sv
// Load/store unit front end: turns one core request at a time into a word-aligned
// memory command, plus a write-data beat or read-data capture, and a one-cycle response.
module lsu_mem_if #(
  parameter int p_ADDR_BITS = 32,
  parameter int p_DATA_BITS = 32,
  parameter int p_STRB_BITS = p_DATA_BITS / 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_cmd,
  input  logic [1:0]             req_size,
  input  logic                   req_unsigned,
  input  logic [p_ADDR_BITS-1:0] req_addr,
  input  logic [p_DATA_BITS-1:0] req_wdata,
  output logic                   rsp_valid,
  output logic [p_DATA_BITS-1:0] rsp_rdata,
  output logic                   rsp_err,
  output logic [p_ADDR_BITS-1:0] mem_addr,
  output logic                   mem_cmd,
  output logic [1:0]             mem_size,
  output logic                   mem_valid,
  input  logic                   mem_ready,
  output logic                   mem_r_ready,
  input  logic                   mem_r_valid,
  input  logic [p_DATA_BITS-1:0] mem_r_data,
  input  logic                   mem_r_resp,
  output logic                   mem_w_valid,
  input  logic                   mem_w_ready,
  output logic [p_STRB_BITS-1:0] mem_w_strb,
  output logic [p_DATA_BITS-1:0] mem_w_data,
  input  logic                   mem_w_resp
);

  typedef enum logic [1:0] {IDLE, CMD, RDATA} state_t;

  state_t state, state_next;

  logic       cmd_q;
  logic [1:0] size_q;
  logic       uns_q;
  logic [1:0] addr_lo;
  logic       cmd_done;
  logic       wdat_done;
  logic       wresp_q;

  logic accept, illegal, cmd_hs, w_hs, load_fin, store_fin;
  logic [p_STRB_BITS-1:0] strb_new;
  logic [p_DATA_BITS-1:0] wdata_new;
  logic [p_DATA_BITS-1:0] lane;
  logic [p_DATA_BITS-1:0] load_ext;

  assign illegal = (req_size == 2'd3) ||
                   (req_size == 2'd1 && req_addr[0]) ||
                   (req_size == 2'd2 && req_addr[1:0] != 2'b00);

  always_comb begin
    strb_new  = '0;
    wdata_new = '0;
    case (req_size)
      2'd0: begin
        strb_new  = p_STRB_BITS'(1) << req_addr[1:0];
        wdata_new = {(p_DATA_BITS/8){req_wdata[7:0]}};
      end
      2'd1: begin
        strb_new  = p_STRB_BITS'(3) << req_addr[1:0];
        wdata_new = {(p_DATA_BITS/16){req_wdata[15:0]}};
      end
      default: begin
        strb_new  = '1;
        wdata_new = req_wdata;
      end
    endcase
  end

  // Read word is shifted down to the addressed lane, then sign/zero extended.
  always_comb begin
    lane     = mem_r_data >> {addr_lo, 3'b000};
    load_ext = lane;
    case (size_q)
      2'd0: load_ext = uns_q ? {{(p_DATA_BITS-8){1'b0}}, lane[7:0]}
                             : {{(p_DATA_BITS-8){lane[7]}}, lane[7:0]};
      2'd1: load_ext = uns_q ? {{(p_DATA_BITS-16){1'b0}}, lane[15:0]}
                             : {{(p_DATA_BITS-16){lane[15]}}, lane[15:0]};
      default: load_ext = lane;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  // A store finishes once both the command and data handshakes have happened, in
  // either order; a load leaves CMD on its command handshake.
  always_comb begin
    state_next  = state;
    req_ready   = 1'b0;
    mem_valid   = 1'b0;
    mem_w_valid = 1'b0;
    mem_r_ready = 1'b0;
    accept      = 1'b0;
    cmd_hs      = 1'b0;
    w_hs        = 1'b0;
    load_fin    = 1'b0;
    store_fin   = 1'b0;
    case (state)
      IDLE: begin
        req_ready = rst;
        accept    = req_valid;
        if (accept && !illegal) state_next = CMD;
      end
      CMD: begin
        mem_valid   = !cmd_done;
        mem_w_valid = cmd_q && !wdat_done;
        mem_r_ready = !cmd_q;
        cmd_hs      = mem_valid && mem_ready;
        w_hs        = mem_w_valid && mem_w_ready;
        if (cmd_q) begin
          store_fin = (cmd_done || cmd_hs) && (wdat_done || w_hs);
          if (store_fin) state_next = IDLE;
        end else if (cmd_hs) begin
          load_fin   = mem_r_valid;
          state_next = mem_r_valid ? IDLE : RDATA;
        end
      end
      RDATA: begin
        mem_r_ready = 1'b1;
        load_fin    = mem_r_valid;
        if (mem_r_valid) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cmd_q      <= 1'b0;
      size_q     <= 2'd0;
      uns_q      <= 1'b0;
      addr_lo    <= 2'd0;
      cmd_done   <= 1'b0;
      wdat_done  <= 1'b0;
      wresp_q    <= 1'b0;
      mem_addr   <= '0;
      mem_cmd    <= 1'b0;
      mem_size   <= 2'd0;
      mem_w_strb <= '0;
      mem_w_data <= '0;
      rsp_valid  <= 1'b0;
      rsp_rdata  <= '0;
      rsp_err    <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      if (accept) begin
        if (illegal) begin
          rsp_valid <= 1'b1;
          rsp_err   <= 1'b1;
          rsp_rdata <= '0;
        end else begin
          cmd_q      <= req_cmd;
          size_q     <= req_size;
          uns_q      <= req_unsigned;
          addr_lo    <= req_addr[1:0];
          cmd_done   <= 1'b0;
          wdat_done  <= 1'b0;
          wresp_q    <= 1'b0;
          mem_addr   <= {req_addr[p_ADDR_BITS-1:2], 2'b00};
          mem_cmd    <= req_cmd;
          mem_size   <= req_size;
          mem_w_strb <= req_cmd ? strb_new : '0;
          mem_w_data <= req_cmd ? wdata_new : '0;
        end
      end
      if (cmd_hs) cmd_done <= 1'b1;
      if (w_hs) begin
        wdat_done <= 1'b1;
        wresp_q   <= mem_w_resp;
      end
      if (store_fin) begin
        rsp_valid <= 1'b1;
        rsp_err   <= w_hs ? mem_w_resp : wresp_q;
        rsp_rdata <= '0;
      end
      if (load_fin) begin
        rsp_valid <= 1'b1;
        rsp_err   <= mem_r_resp;
        rsp_rdata <= load_ext;
      end
    end
  end

endmodule
